// File: rtl/axrm_div16x8.sv
// ---------------------------------------------------------------------------
// axrm_div16x8 -- sequential restoring divider, 16-bit dividend / 8-bit divisor
//
// Recovers the unknown operand (and remainder) from a product of the 8x8
// recursive multipliers. One quotient bit is produced per cycle, MSB first.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   product, b          dividend and divisor
//   out_valid/out_ready result handshake; result held until accepted
//   quotient, remainder product / b, product mod b
//   div_by_zero         result came from b == 0 (quotient=FFFF, rem=product[7:0])
//
// Build option
//   AXRM_DIV_APPROX_EN  drop product[1:0] at accept and divide product[15:2]
//                       in 14 iterations; quotient is returned shifted left by 2.
// ---------------------------------------------------------------------------
module axrm_div16x8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] product,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

`ifdef AXRM_DIV_APPROX_EN
    localparam int ITERS = 14;
`else
    localparam int ITERS = 16;
`endif
    localparam logic [4:0] LAST = 5'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [15:0] q_reg;   // dividend bits shift out the top, quotient bits in at the bottom
    logic [7:0]  d_reg;
    logic [7:0]  r;       // partial remainder; always < d_reg, so its 9th bit is always 0
    logic [4:0]  cnt;

    // One restoring step. t keeps all 9 bits for the compare; the difference
    // is known to be < d_reg when taken, so 8-bit modular subtraction is exact.
    logic [8:0]  t;
    logic        ge;
    logic [7:0]  t_sub;
    logic [15:0] q_shift;

    assign t       = {r, q_reg[15]};
    assign ge      = (t >= {1'b0, d_reg});
    assign t_sub   = t[7:0] - d_reg;
    assign q_shift = {q_reg[14:0], ge};

    assign quotient  = q_reg;
    assign remainder = r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q_reg       <= '0;
            d_reg       <= '0;
            r           <= '0;
            cnt         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        d_reg    <= b;
                        cnt      <= '0;
                        if (b == 8'd0) begin
                            q_reg       <= 16'hFFFF;
                            r           <= product[7:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
`ifdef AXRM_DIV_APPROX_EN
                            // Top-align the 14 kept bits so the MSB-first loop sees them first.
                            q_reg <= {product[15:2], 2'b00};
`else
                            q_reg <= product;
`endif
                            r           <= '0;
                            div_by_zero <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r   <= ge ? t_sub : t[7:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
`ifdef AXRM_DIV_APPROX_EN
                        // Low 14 bits are the quotient; scale back by 4.
                        q_reg <= {q_reg[12:0], ge, 2'b00};
`else
                        q_reg <= q_shift;
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        q_reg <= q_shift;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axrm_div16x8.md
# axrm_div16x8

Sequential restoring divider that takes a 16-bit product and an 8-bit operand and recovers the other operand, plus the remainder. It is the inverse path to the 8x8 recursive multipliers. It sits behind them in the error-characterization datapath: a product (exact or approximate) is divided by the known operand to measure how far the recovered operand deviates. Operands enter and results leave over valid/ready handshakes.

## Interface
- Parameters: none. Widths are fixed at 16-bit dividend / 8-bit divisor to pair with the 8x8 multipliers.
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  a product/operand pair is offered
- in_ready  out  1  block can accept; high only in IDLE
- product  in  16  dividend
- b  in  8  divisor
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream accepts the result
- quotient  out  16  product / b
- remainder  out  8  product mod b
- div_by_zero  out  1  result came from b == 0

## Operation
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid: latch product into q_reg and b into d_reg, clear the 9-bit partial remainder r, clear iter count.
  - If b==0, go to DONE. Otherwise go to BUSY.
- BUSY, one iteration per cycle, 16 iterations:
  - t = {r[7:0], q_reg[15]}, 9-bit.
  - If t >= {1'b0, d_reg}: r = t - d_reg, and shift 1 into q_reg LSB. Otherwise r = t, and shift 0 into q_reg LSB.
  - The compare is 9-bit unsigned; no truncation before compare.
  - After the last iteration, go to DONE.
- DONE
  - out_valid=1.
  - quotient=q_reg, remainder=r[7:0].
  - Outputs are held stable until out_valid && out_ready, then go to IDLE.
- Divide by zero: quotient=16'hFFFF, remainder=product[7:0], div_by_zero=1. No iterations run.
- div_by_zero is 0 for every nonzero divisor.
- Reset values: in_ready=0 during reset and 1 after, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- Reset asserted mid-BUSY or in DONE aborts the operation immediately. The result is discarded and the block returns to IDLE.
- in_valid outside IDLE is ignored; inputs may change freely while not accepted.

## Timing
- Accept edge = cycle 0 (in_valid && in_ready).
- Nonzero divisor: BUSY occupies cycles 1..16; out_valid rises after edge 16, so it is first sampled high at cycle 17. Latency is 17 cycles.
- Zero divisor: out_valid is high at cycle 1.
- Output handshake at edge N: out_valid=0 and in_ready=1 at cycle N+1. There is no same-cycle result-drain plus new accept.
- Throughput is one division per 18 cycles with out_ready held high.
- out_valid never drops without a handshake or reset.

## Configuration
- AXRM_DIV_APPROX_EN defined:
  - Approximate mode mirroring the multipliers' low-bit truncation.
  - product[1:0] is dropped at accept; BUSY runs 14 iterations on product[15:2].
  - quotient = (product[15:2] / b) << 2; remainder = product[15:2] mod b.
  - Latency is 15 cycles.
  - Divide-by-zero behaviour is unchanged.
- Not defined: exact 16-iteration behaviour as above.

## Test plan
- product=200, b=7, out_ready=1 -> quotient=28, remainder=4, div_by_zero=0, out_valid at cycle 17 (approx build: quotient=28, remainder=1, cycle 15).
- product=65535, b=1 -> quotient=65535, remainder=0. Also product=0xFFFF, b=0xFF -> quotient=257, remainder=0.
- product=100, b=0 -> quotient=0xFFFF, remainder=0x64, div_by_zero=1, out_valid at cycle 1.
- product=203, b=5, out_ready held low 5 cycles after out_valid -> outputs stay at 40/3 (approx build: 40/0) and in_ready stays 0; in_ready=1 the cycle after out_ready rises.
- rst_n pulsed low at BUSY cycle 8 of product=1000, b=3 -> out_valid never rises, in_ready=1 after release. Next op 1000/3 -> 333/1.
- in_valid held with changing product during BUSY -> result reflects only the first accepted pair.
